// File: rtl/fp_normalize.sv
// fp_normalize: post-add normalization stage of the FP ALU datapath.
// Takes the raw carry+significand sum, normalizes it one bit per cycle and
// packs an IEEE-754 single-precision word (truncation rounding).
module fp_normalize #(
    parameter int unsigned MANT_W = 24,
    parameter int unsigned EXP_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [MANT_W:0]         in_mant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MANT_W-1:0] out_result,
    output logic                    out_ovf,
    output logic                    out_unf,
    output logic                    busy
);

    localparam int unsigned FRAC_W = MANT_W - 1;
    localparam int unsigned MAG_W  = EXP_W + FRAC_W;

    localparam logic [EXP_W-1:0] EXP_MAX     = '1;
    localparam logic [EXP_W-1:0] EXP_OVF_LIM = EXP_MAX - EXP_W'(1);
    localparam logic [EXP_W-1:0] EXP_ONE     = EXP_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SHIFT,
        PACK,
        DONE
    } state_t;

    state_t                    r_state;
    logic                      r_sign;
    logic [EXP_W-1:0]          r_exp;
    logic [MANT_W:0]           r_mant;
    logic                      r_out_valid;
    logic [EXP_W+MANT_W-1:0]   r_out_result;
    logic                      r_ovf;
    logic                      r_unf;

    // Ready only while idle; reset masks it so nothing is accepted during reset.
    assign in_ready   = (r_state == IDLE) && !reset;
    assign busy       = (r_state != IDLE);
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_ovf    = r_ovf;
    assign out_unf    = r_unf;

    // Control FSM: classify, normalize one bit per cycle, pack and hand off.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_sign       <= 1'b0;
            r_exp        <= '0;
            r_mant       <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_ovf        <= 1'b0;
            r_unf        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign  <= in_sign;
                        r_exp   <= in_exp;
                        r_mant  <= in_mant;
                        r_state <= CHECK;
                    end
                end

                CHECK: begin
                    if (r_exp == EXP_MAX) begin
                        // Infinite/NaN exponent in: saturate to signed infinity.
                        r_out_result <= {r_sign, EXP_MAX, FRAC_W'(0)};
                        r_ovf        <= 1'b1;
                        r_unf        <= 1'b0;
                        r_state      <= DONE;
                    end else if (r_mant == '0) begin
                        // Exact cancellation always yields +0.
                        r_out_result <= '0;
                        r_ovf        <= 1'b0;
                        r_unf        <= 1'b0;
                        r_state      <= DONE;
                    end else if (r_exp == '0) begin
                        r_out_result <= {r_sign, MAG_W'(0)};
                        r_ovf        <= 1'b0;
                        r_unf        <= 1'b1;
                        r_state      <= DONE;
                    end else if (r_mant[MANT_W]) begin
                        if (r_exp == EXP_OVF_LIM) begin
                            r_out_result <= {r_sign, EXP_MAX, FRAC_W'(0)};
                            r_ovf        <= 1'b1;
                            r_unf        <= 1'b0;
                            r_state      <= DONE;
                        end else begin
                            // Carry out: one right shift, LSB truncated.
                            r_mant  <= r_mant >> 1;
                            r_exp   <= r_exp + EXP_ONE;
                            r_state <= PACK;
                        end
                    end else if (r_mant[MANT_W-1]) begin
                        r_state <= PACK;
                    end else begin
                        r_state <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (r_exp == EXP_ONE) begin
                        // Next shift would need exponent 0: flush to signed zero.
                        r_out_result <= {r_sign, MAG_W'(0)};
                        r_ovf        <= 1'b0;
                        r_unf        <= 1'b1;
                        r_state      <= DONE;
                    end else begin
                        r_mant <= r_mant << 1;
                        r_exp  <= r_exp - EXP_ONE;
                        if (r_mant[MANT_W-2]) begin
                            r_state <= PACK;
                        end
                    end
                end

                PACK: begin
                    r_out_result <= {r_sign, r_exp, r_mant[FRAC_W-1:0]};
                    r_ovf        <= 1'b0;
                    r_unf        <= 1'b0;
                    r_state      <= DONE;
                end

                DONE: begin
                    // Raise valid one cycle after the result settles, hold until taken.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_normalize.sv
// tb_fp_normalize: directed and randomized checks of fp_normalize against an
// arithmetic reference model (leading-one position, shift count, exponent range).
module tb_fp_normalize;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf;
    logic        out_unf;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    fp_normalize #(.MANT_W(24), .EXP_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .out_unf    (out_unf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    endtask

    // Reference: normalize by locating the leading one, then range-check the exponent.
    function automatic void model(input logic s, input int e, input logic [24:0] m,
                                  output logic [31:0] res, output logic ovf,
                                  output logic unf, output int lat);
        int p;
        int k;
        logic [24:0] n;
        res = 32'h0; ovf = 1'b0; unf = 1'b0; lat = 2;
        if (e == 255) begin
            res = {s, 8'hFF, 23'd0}; ovf = 1'b1;
        end else if (m == 25'd0) begin
            res = 32'h0;
        end else if (e == 0) begin
            res = {s, 31'd0}; unf = 1'b1;
        end else if (m[24]) begin
            if (e == 254) begin
                res = {s, 8'hFF, 23'd0}; ovf = 1'b1;
            end else begin
                n = m >> 1;
                res = {s, 8'(e + 1), n[22:0]};
                lat = 3;
            end
        end else begin
            p = 0;
            for (int i = 0; i < 24; i++) if (m[i]) p = i;
            k = 23 - p;
            if (e <= k) begin
                // Exponent would reach 0 before the hidden bit is set.
                res = {s, 31'd0}; unf = 1'b1; lat = e + 2;
            end else begin
                n = m << k;
                res = {s, 8'(e - k), n[22:0]};
                lat = 3 + k;
            end
        end
    endfunction

    task automatic run_op(input logic s, input int e, input logic [24:0] m,
                          input int hold, output logic [31:0] got);
        logic [31:0] w_res;
        logic        w_ovf;
        logic        w_unf;
        int          w_lat;
        int          n;
        logic [31:0] snap;
        model(s, e, m, w_res, w_ovf, w_unf, w_lat);
        @(negedge clk);
        in_sign  = s;
        in_exp   = 8'(e);
        in_mant  = m;
        in_valid = 1'b1;
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            check_eq("in_ready_busy", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        check_eq("latency", 32'(n), 32'(w_lat));
        check_eq("result", out_result, w_res);
        check_eq("ovf", 32'(out_ovf), 32'(w_ovf));
        check_eq("unf", 32'(out_unf), 32'(w_unf));
        got  = out_result;
        snap = out_result;
        // Backpressure: output must hold and a new request must be refused.
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_mant  = 25'($urandom);
            @(posedge clk); #1;
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_result", out_result, snap);
            check_eq("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("drain_valid", 32'(out_valid), 32'd0);
        check_eq("drain_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] got;
        logic        s;
        int          e;
        int          kind;
        int          pos;
        logic [24:0] m;
        logic [24:0] bitp;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 8'd0;
        in_mant   = 25'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_result", out_result, 32'h0);
        check_eq("rst_ovf", 32'(out_ovf), 32'd0);
        check_eq("rst_unf", 32'(out_unf), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed cases with literal expected words.
        run_op(1'b0, 127, 25'h0800000, 0, got); check_eq("dir_normal", got, 32'h3F800000);
        run_op(1'b0, 127, 25'h1000000, 0, got); check_eq("dir_carry", got, 32'h40000000);
        run_op(1'b0, 127, 25'h1000001, 0, got); check_eq("dir_carry_trunc", got, 32'h40000000);
        run_op(1'b0, 127, 25'h0000001, 0, got); check_eq("dir_walk23", got, 32'h34000000);
        run_op(1'b1, 127, 25'h0000000, 0, got); check_eq("dir_zero", got, 32'h00000000);
        run_op(1'b1, 254, 25'h1800000, 0, got); check_eq("dir_ovf", got, 32'hFF800000);
        run_op(1'b1, 5,   25'h0000100, 0, got); check_eq("dir_unf", got, 32'h80000000);
        run_op(1'b0, 127, 25'h0800000, 5, got); check_eq("dir_backpressure", got, 32'h3F800000);

        // Reset during the 10th shift cycle of a full cancellation walk.
        @(negedge clk);
        in_sign  = 1'b0;
        in_exp   = 8'd127;
        in_mant  = 25'h0000001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("mid_busy", 32'(busy), 32'd1);
        check_eq("mid_no_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_valid", 32'(out_valid), 32'd0);
        check_eq("abort_result", out_result, 32'h0);
        check_eq("abort_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(1'b0, 127, 25'h0800000, 0, got); check_eq("post_abort", got, 32'h3F800000);

        // Randomized operations biased toward exponent and mantissa boundaries.
        for (int t = 0; t < 200; t++) begin
            s = 1'($urandom);
            case ($urandom_range(0, 9))
                0:       e = 255;
                1:       e = 0;
                2:       e = 254;
                3:       e = 1;
                4:       e = $urandom_range(1, 24);
                default: e = $urandom_range(1, 254);
            endcase
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                m = 25'd0;
            end else if (kind <= 2) begin
                m = 25'h1000000 | (25'($urandom) & 25'h0FFFFFF);
            end else begin
                pos  = $urandom_range(0, 23);
                bitp = 25'd1 << pos;
                m    = bitp | (25'($urandom) & (bitp - 25'd1));
            end
            run_op(s, e, m, $urandom_range(0, 2), got);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fp_normalize.md
Name: fp_normalize

Overview:
- Post-add normalization stage of the FP ALU datapath, directly downstream of the mantissa alignment shifter and adder.
- Takes the raw 25-bit mantissa sum/difference (carry bit + 24-bit significand), the common exponent and the result sign.
- Normalizes iteratively: a one-bit right shift on carry, otherwise one left shift per cycle until the hidden bit is set.
- Packs an IEEE-754 single-precision word. Rounding is truncation, matching the alignment stage.
- Uses a valid/ready handshake on both sides and processes one operation at a time.

Parameters:
- MANT_W, 24, significand width including hidden bit (fraction = MANT_W-1 bits).
- EXP_W, 8, exponent width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input operation valid
- in_ready  out  1  block can accept an operation
- in_sign  in  1  result sign
- in_exp  in  8  biased common exponent (larger operand exponent)
- in_mant  in  25  raw sum; bit 24 = carry, bit 23 = hidden-bit position
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  32  packed {sign, exp[7:0], frac[22:0]}
- out_ovf  out  1  overflow flag, valid with out_valid
- out_unf  out  1  underflow (flush-to-zero) flag, valid with out_valid
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, active-high) values: state IDLE, out_valid 0, out_result 0, out_ovf 0, out_unf 0, busy 0.
- While reset is high, in_ready is forced 0 and inputs are ignored. Reset in any state aborts the in-flight operation with no output.
- in_ready = 1 only in IDLE. Accept occurs on a clock edge with in_valid & in_ready. That edge latches sign, exp and mant into internal registers and moves the FSM to CHECK.
- CHECK (one cycle), priority order:
  1. in_exp == 8'hFF: result {sign, 8'hFF, 23'b0}, ovf = 1 -> DONE.
  2. mant == 0: result 32'h0 (+0, sign dropped) -> DONE.
  3. in_exp == 0 (nonzero mant): result {sign, 31'b0}, unf = 1 -> DONE.
  4. mant[24] = 1 and exp == 254: result {sign, 8'hFF, 23'b0}, ovf = 1 -> DONE.
  5. mant[24] = 1 and exp < 254: mant >>= 1 (LSB dropped), exp += 1 -> PACK.
  6. mant[23] = 1 -> PACK.
  7. Otherwise -> SHIFT.
- SHIFT (one cycle per left shift):
  - If exp == 1, unf = 1 and result {sign, 31'b0} -> DONE.
  - Otherwise mant <<= 1 and exp -= 1. Go to PACK if the pre-shift mant[22] = 1; else stay in SHIFT.
  - At most 23 shifts occur, because a nonzero 24-bit value always reaches bit 23.
- PACK (one cycle): out_result <= {sign, exp, mant[22:0]}, ovf = unf = 0 -> DONE.
- DONE:
  - out_valid = 1.
  - out_result, out_ovf and out_unf are held stable until out_ready is sampled high.
  - On that edge out_valid falls and the FSM returns to IDLE. The next operation can be accepted one cycle later (no same-cycle turnaround).
- Latency from the accept edge t:
  - Normal result with k left shifts: out_valid rises at edge t+3+k. Cases: k=0 -> t+3; carry case -> t+3; k=23 -> t+26.
  - Special cases resolved in CHECK (zero, ovf, unf): out_valid rises at t+2.
  - Underflow detected in SHIFT after j shifts: out_valid rises at t+3+j.
- Flags are mutually exclusive. Flags and out_result are meaningful only while out_valid = 1.
- Arithmetic: exponent increment and decrement are 8-bit unsigned. Wrap is impossible because of the exp == 254 and exp == 1 guards.

Test Plan:
- Normal: sign 0, exp 127, mant 0x0800000 -> out_result 0x3F800000, no flags, out_valid at accept+3, in_ready 0 until return to IDLE.
- Carry (1.0 + 1.0): sign 0, exp 127, mant 0x1000000 -> 0x40000000 at accept+3. Repeat with mant 0x1000001 -> 0x40000000 (truncation drops the LSB).
- Full cancellation walk: exp 127, mant 0x0000001 -> 23 shifts, out_result 0x34000000 (exp 104) at accept+26. Also mant 0 -> 0x00000000 at accept+2, no flags.
- Overflow/underflow:
  - sign 1, exp 254, mant 0x1800000 -> 0xFF800000, out_ovf = 1 at accept+2.
  - sign 1, exp 5, mant 0x0000100 -> 4 shifts then out_unf = 1, out_result 0x80000000 at accept+7.
- Backpressure: hold out_ready low for 5 cycles in DONE -> out_valid and out_result stable, in_ready 0, a presented in_valid is not accepted. Raise out_ready -> IDLE next cycle, then accept.
- Reset mid-operation: assert reset during the 10th SHIFT cycle of the cancellation case -> next edge shows IDLE, out_valid 0, out_result 0, no stale output. A following normal operation completes correctly.
